// File: rtl/usart_tx_buffered.sv
// Buffered 8N1 USART transmitter: byte FIFO feeding a serialiser with a programmable bit period.
// Define USART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module usart_tx_buffered #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          comm_clock,
    input  logic          reset_n,
    input  logic [11:0]   clock_divider,
    input  logic [7:0]    data_in,
    input  logic          write,
    input  logic          clear_overflow,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          overflow,
    output logic          tx_pin,
    output logic [2:0]    fsm_state
);

    // Handshake: write is a single-cycle enqueue strobe with no ready; a strobe while full
    // is dropped and recorded in the sticky overflow flag. Bytes leave only at frame start.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_next;
    logic [7:0]    head;
    logic [7:0]    shift;
    logic [11:0]   n_lat;
    logic [11:0]   n_sel;
    logic [11:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic          bit_last;
    logic          push;
    logic          pop;
`ifdef USART_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign head      = mem[rd_ptr];
    assign push      = write && !full;
    assign bit_last  = (bit_cnt == n_lat - 12'd1);
    assign n_sel     = (clock_divider == 12'd0) ? 12'd1 : clock_divider;
    assign fsm_state = state;

    // A pop only ever coincides with a frame start: from IDLE, or chained off the last stop cycle.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == ST_IDLE)
                pop = 1'b1;
            else if (state == ST_STOP && bit_last)
                pop = 1'b1;
        end
    end

    always_comb begin
        level_next = level;
        if (push && !pop)
            level_next = level + 1'b1;
        else if (!push && pop)
            level_next = level - 1'b1;
    end

    always_ff @(posedge comm_clock) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full  <= (level_next == FULL_LEVEL);
            empty <= (level_next == '0);
            // Setting has priority over clearing so a same-cycle drop is never lost.
            if (write && full)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            tx_pin     <= 1'b1;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            n_lat      <= 12'd1;
            shift      <= '0;
`ifdef USART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift      <= head;
                        n_lat      <= n_sel;
                        bit_cnt    <= '0;
                        state      <= ST_START;
                        tx_pin     <= 1'b0;
                        busy       <= 1'b1;
`ifdef USART_TX_PARITY_EN
                        parity_bit <= ^head;
`endif
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx_pin  <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + 12'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef USART_TX_PARITY_EN
                            state  <= ST_PARITY;
                            tx_pin <= parity_bit;
`else
                            state  <= ST_STOP;
                            tx_pin <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_pin  <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 12'd1;
                    end
                end
`ifdef USART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                        tx_pin  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 12'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift      <= head;
                            n_lat      <= n_sel;
                            state      <= ST_START;
                            tx_pin     <= 1'b0;
`ifdef USART_TX_PARITY_EN
                            parity_bit <= ^head;
`endif
                        end else begin
                            state  <= ST_IDLE;
                            tx_pin <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 12'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_pin <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_tx_buffered.sv
// Self-checking bench for usart_tx_buffered: scoreboard of queued bytes, tx_pin frame monitor.
// Frame expectations come from the serial frame format, not from the design's internals.
module tb_usart_tx_buffered;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef USART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          comm_clock;
    logic          reset_n;
    logic [11:0]   clock_divider;
    logic [7:0]    data_in;
    logic          write;
    logic          clear_overflow;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          busy;
    logic          overflow;
    logic          tx_pin;
    logic [2:0]    fsm_state;

    usart_tx_buffered #(.DEPTH(DEPTH)) dut (
        .comm_clock     (comm_clock),
        .reset_n        (reset_n),
        .clock_divider  (clock_divider),
        .data_in        (data_in),
        .write          (write),
        .clear_overflow (clear_overflow),
        .full           (full),
        .empty          (empty),
        .level          (level),
        .busy           (busy),
        .overflow       (overflow),
        .tx_pin         (tx_pin),
        .fsm_state      (fsm_state)
    );

    // Clock and cycle counter
    initial comm_clock = 1'b0;
    always #5 comm_clock = ~comm_clock;

    int cyc = 0;
    always @(posedge comm_clock) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] exp_q[$];
    int         exp_n[$];
    int         start_cyc[$];
    int         model_level = 0;
    int         cur_n = 1;
    int         last_wcyc = 0;
    bit         mon_en = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Line level for frame bit idx: start, 8 data LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef USART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Driver tasks
    task automatic set_div(input int d);
        clock_divider = 12'(d);
        cur_n = (d == 0) ? 1 : d;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge comm_clock);
        data_in = b;
        write   = 1'b1;
        @(posedge comm_clock);
        #1;
        last_wcyc = cyc;
        if (model_level < DEPTH) begin
            exp_q.push_back(b);
            exp_n.push_back(cur_n);
            model_level++;
        end
        write = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0 && empty == 1'b1) && k < budget) begin
            @(negedge comm_clock);
            k++;
        end
        check("drain_within_budget", int'(k < budget), 1);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (start_cyc.size() < n && k < budget) begin
            @(negedge comm_clock);
            k++;
        end
        check("frame_start_seen", int'(start_cyc.size() >= n), 1);
    endtask

    // Monitor: decodes every frame on tx_pin and compares against the scoreboard head
    logic [7:0] mon_b;
    int         mon_n;
    int         mon_bad;
    int         mon_busy_bad;
    int         mon_wait;

    initial begin
        forever begin
            @(negedge comm_clock);
            if (mon_en && reset_n && tx_pin == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_start", 1, 0);
                    mon_wait = 0;
                    while (tx_pin == 1'b0 && mon_wait < 20000) begin
                        @(negedge comm_clock);
                        mon_wait++;
                    end
                end else begin
                    mon_b = exp_q.pop_front();
                    mon_n = exp_n.pop_front();
                    start_cyc.push_back(cyc);
                    model_level--;
                    mon_busy_bad = 0;
                    for (int i = 0; i < NBITS; i++) begin
                        mon_bad = 0;
                        for (int s = 0; s < mon_n; s++) begin
                            if (!(i == 0 && s == 0))
                                @(negedge comm_clock);
                            if (tx_pin !== exp_bit(mon_b, i))
                                mon_bad++;
                            if (busy !== 1'b1)
                                mon_busy_bad++;
                        end
                        check($sformatf("frame_%02h_bit%0d_wrong_samples", mon_b, i), mon_bad, 0);
                    end
                    check($sformatf("frame_%02h_busy_low_samples", mon_b), mon_busy_bad, 0);
                end
            end
        end
    end

    // Main stimulus
    initial begin
        reset_n        = 1'b0;
        write          = 1'b0;
        data_in        = '0;
        clear_overflow = 1'b0;
        set_div(4);
        repeat (3) @(posedge comm_clock);
        #1;
        check("reset_tx_pin", int'(tx_pin), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        check("reset_level", int'(level), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_state_idle", int'(fsm_state), 0);
        @(negedge comm_clock);
        reset_n = 1'b1;

        // Single frame, N=4, start latency of one cycle
        set_div(4);
        start_cyc.delete();
        write_byte(8'h55);
        wait_starts(1, 100);
        if (start_cyc.size() >= 1)
            check("start_latency", start_cyc[0] - last_wcyc, 1);
        wait_drain(200);
        check("idle_busy_after_frame", int'(busy), 0);
        check("idle_tx_after_frame", int'(tx_pin), 1);

        // Back-to-back frames at N=1 with no gap
        set_div(1);
        start_cyc.delete();
        write_byte(8'hA3);
        write_byte(8'h0F);
        wait_starts(2, 100);
        if (start_cyc.size() >= 2) begin
            check("b2b_frame_spacing", start_cyc[1] - start_cyc[0], NBITS);
            check("b2b_empty_after_second_pop", int'(empty), 1);
        end
        wait_drain(200);

        // Divider change mid-frame is ignored; next frame uses the new value
        set_div(4);
        write_byte(8'h81);
        repeat (10) @(negedge comm_clock);
        set_div(8);
        wait_drain(400);
        write_byte(8'h3C);
        wait_drain(400);

        // Divider 0 behaves as 1
        set_div(0);
        write_byte(8'hC6);
        wait_drain(100);

        // Randomized bursts at random bit periods
        for (int r = 0; r < 6; r++) begin
            int burst;
            set_div($urandom_range(0, 7));
            burst = $urandom_range(1, 6);
            for (int w = 0; w < burst; w++) begin
                write_byte(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 3)) @(negedge comm_clock);
            end
            wait_drain(2000);
        end

        // Fill past capacity at a slow bit period
        set_div(100);
        for (int w = 0; w < 18; w++)
            write_byte(8'(8'h10 + w));
        check("ovf_level", int'(level), 16);
        check("ovf_full", int'(full), 1);
        check("ovf_empty", int'(empty), 0);
        check("ovf_flag_set", int'(overflow), 1);
        @(negedge comm_clock);
        clear_overflow = 1'b1;
        @(posedge comm_clock);
        #1;
        clear_overflow = 1'b0;
        check("ovf_flag_cleared", int'(overflow), 0);
        clear_overflow = 1'b1;
        write_byte(8'hEE);
        clear_overflow = 1'b0;
        check("ovf_set_beats_clear", int'(overflow), 1);
        check("ovf_level_unchanged", int'(level), 16);
        wait_drain(20000);

        // Reset in the middle of data bit 3 (0x52 has bit 3 = 0)
        mon_en = 1'b0;
        set_div(4);
        write_byte(8'h52);
        write_byte(8'h11);
        repeat (17) @(posedge comm_clock);
        @(negedge comm_clock);
        check("pre_reset_tx_bit3", int'(tx_pin), 0);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_level", int'(level), 1);
        reset_n = 1'b0;
        @(posedge comm_clock);
        #1;
        check("mid_reset_tx_pin", int'(tx_pin), 1);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_level", int'(level), 0);
        check("mid_reset_empty", int'(empty), 1);
        check("mid_reset_overflow", int'(overflow), 0);
        exp_q.delete();
        exp_n.delete();
        model_level = 0;
        @(negedge comm_clock);
        reset_n = 1'b1;
        repeat (3) @(negedge comm_clock);
        check("post_reset_idle_tx", int'(tx_pin), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
